// File: rtl/song_reader_pkg.sv
// Shared defaults and FSM state encoding for the song reader.
package song_reader_pkg;

    localparam int unsigned NOTE_W_DEF = 6;
    localparam int unsigned DUR_W_DEF  = 6;
    localparam int unsigned OFS_W_DEF  = 5;
    localparam int unsigned SONG_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_ROM  = 3'd2,
        ST_CHECK     = 3'd3,
        ST_WAIT_NOTE = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/song_reader_rom.sv
// Song ROM: four songs of 2^OFS_W words {note, duration}, one-cycle registered read.
// Contents are a constant table so the block synthesizes without a memory init file.
module song_rom
    import song_reader_pkg::*;
#(
    parameter int unsigned NOTE_W = NOTE_W_DEF,
    parameter int unsigned DUR_W  = DUR_W_DEF,
    parameter int unsigned OFS_W  = OFS_W_DEF
) (
    input  logic                      clk,
    input  logic [SONG_W+OFS_W-1:0]   addr,
    output logic [NOTE_W+DUR_W-1:0]   data
);

    logic [31:0]             ofs_w;
    logic [NOTE_W-1:0]       note_v;
    logic [DUR_W-1:0]        dur_v;
    logic [NOTE_W+DUR_W-1:0] data_d;
    logic [NOTE_W+DUR_W-1:0] data_q;

    assign ofs_w = 32'(addr[OFS_W-1:0]);

    always_comb begin
        note_v = '0;
        dur_v  = '0;
        case (addr[OFS_W +: SONG_W])
            2'd0: begin
                note_v = NOTE_W'(ofs_w + 32'd1);
                dur_v  = DUR_W'(ofs_w + 32'd2);
            end
            // Two-note song; every remaining word is {0,0}, usable as an end marker.
            2'd1: begin
                case (ofs_w)
                    32'd0: begin
                        note_v = NOTE_W'(32'd10);
                        dur_v  = DUR_W'(32'd12);
                    end
                    32'd1: begin
                        note_v = NOTE_W'(32'd20);
                        dur_v  = DUR_W'(32'd6);
                    end
                    default: begin
                        note_v = '0;
                        dur_v  = '0;
                    end
                endcase
            end
            2'd2: begin
                note_v = NOTE_W'(32'd63 - ofs_w);
                dur_v  = DUR_W'(ofs_w + 32'd1);
            end
            default: begin
                note_v = NOTE_W'(ofs_w + 32'd32);
                dur_v  = DUR_W'(32'd48 - ofs_w);
            end
        endcase
        data_d = {note_v, dur_v};
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: steps through a ROM song one note at a time, handshaking with the note player.
// Define SONG_READER_ENDMARK_EN to treat a duration-0 word as end of song.
module song_reader
    import song_reader_pkg::*;
#(
    parameter int unsigned NOTE_W = NOTE_W_DEF,
    parameter int unsigned DUR_W  = DUR_W_DEF,
    parameter int unsigned OFS_W  = OFS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [1:0]        song,
    input  logic              reset_play,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done
);

    state_e                  state_q, state_d;
    logic [OFS_W-1:0]        offset_q, offset_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic [NOTE_W-1:0]       note_q, note_d;
    logic [DUR_W-1:0]        duration_q, duration_d;
    logic                    new_note_q, new_note_d;
    logic                    song_done_q, song_done_d;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic                    end_mark;

    song_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .OFS_W(OFS_W)) u_rom (
        .clk  (clk),
        .addr ({song_q, offset_q}),
        .data (rom_data)
    );

`ifdef SONG_READER_ENDMARK_EN
    assign end_mark = (duration_q == '0);
`else
    assign end_mark = 1'b0;
`endif

    // Pulses are set on the transition, so they are high during the first cycle of the new state.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        song_d      = song_q;
        note_d      = note_q;
        duration_d  = duration_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        if (reset_play) begin
            state_d  = ST_IDLE;
            offset_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_FETCH;
                        song_d  = song;
                    end
                end
                ST_FETCH:    state_d = ST_WAIT_ROM;
                ST_WAIT_ROM: begin
                    state_d    = ST_CHECK;
                    note_d     = rom_data[DUR_W +: NOTE_W];
                    duration_d = rom_data[DUR_W-1:0];
                end
                ST_CHECK: begin
                    if (end_mark) begin
                        state_d     = ST_DONE;
                        song_done_d = 1'b1;
                    end else begin
                        state_d    = ST_WAIT_NOTE;
                        new_note_d = 1'b1;
                    end
                end
                ST_WAIT_NOTE: begin
                    if (note_done) begin
                        if (offset_q == '1) begin
                            state_d     = ST_DONE;
                            song_done_d = 1'b1;
                        end else begin
                            offset_d = offset_q + OFS_W'(1);
                            state_d  = play ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d  = ST_IDLE;
                    offset_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            song_q      <= '0;
            note_q      <= '0;
            duration_q  <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            song_q      <= song_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign note      = note_q;
    assign duration  = duration_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: cycle vector table plus multi-cycle song sequences.
module tb_song_reader;

    logic       clk;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       reset_play;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int n_tests = 0;
    int n_fail  = 0;

    song_reader #(.NOTE_W(6), .DUR_W(6), .OFS_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .song       (song),
        .reset_play (reset_play),
        .note_done  (note_done),
        .note       (note),
        .duration   (duration),
        .new_note   (new_note),
        .song_done  (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       play;
        logic [1:0] song;
        logic       rp;
        logic       nd;
        logic       nn;
        logic       sd;
        logic [5:0] note;
        logic [5:0] dur;
    } vec_t;

    vec_t tbl[26];

    function automatic int exp_note(input int s, input int i);
        case (s)
            0:       return i + 1;
            2:       return 63 - i;
            3:       return i + 32;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_dur(input int s, input int i);
        case (s)
            0:       return i + 2;
            2:       return i + 1;
            3:       return 48 - i;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until new_note or song_done; lat = edges taken (0 if the bound expired).
    task automatic wait_event(output int lat, output logic nn, output logic sd);
        lat = 0;
        nn  = 1'b0;
        sd  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            note_done  = 1'b0;
            reset_play = 1'b0;
            if (new_note === 1'b1 || song_done === 1'b1) begin
                lat = k;
                nn  = new_note;
                sd  = song_done;
                break;
            end
        end
    endtask

    task automatic expect_note(input string name, input int elat, input int en, input int ed);
        int   lat;
        logic nn, sd;
        wait_event(lat, nn, sd);
        chk({name, "/lat"}, lat, elat);
        chk({name, "/new_note"}, nn, 1);
        chk({name, "/note"}, note, en);
        chk({name, "/dur"}, duration, ed);
    endtask

    task automatic expect_done(input string name, input int elat);
        int   lat;
        logic nn, sd;
        wait_event(lat, nn, sd);
        chk({name, "/lat"}, lat, elat);
        chk({name, "/song_done"}, sd, 1);
        chk({name, "/new_note"}, nn, 0);
    endtask

    task automatic play_song(input int s, input int sw);
        song = 2'(s);
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) note_done = 1'b1;
            expect_note($sformatf("s%0d_n%0d", s, i), 4, exp_note(s, i), exp_dur(s, i));
            if (i == 0) song = 2'(sw);
        end
        note_done = 1'b1;
        expect_done($sformatf("s%0d_wrap", s), 1);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && new_note === 1'b1 && song_done === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_overlap: got new_note=1 song_done=1 expected at most one");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           play song rp nd   nn sd note dur
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 2};
        tbl[3]  = '{1, 0, 0, 0, 1, 0, 1, 2};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 2};
        tbl[5]  = '{1, 0, 0, 1, 0, 0, 1, 2};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 2};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 2, 3};
        tbl[8]  = '{1, 0, 0, 0, 1, 0, 2, 3};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 2, 3};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 2, 3};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 2, 3};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 2, 3};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 3, 4};
        tbl[14] = '{1, 0, 0, 0, 1, 0, 3, 4};
        tbl[15] = '{1, 0, 1, 1, 0, 0, 3, 4};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 3, 4};
        tbl[17] = '{1, 0, 0, 0, 0, 0, 3, 4};
        tbl[18] = '{1, 0, 0, 0, 0, 0, 1, 2};
        tbl[19] = '{1, 0, 0, 0, 1, 0, 1, 2};
        tbl[20] = '{1, 3, 0, 0, 0, 0, 1, 2};
        tbl[21] = '{1, 3, 0, 1, 0, 0, 1, 2};
        tbl[22] = '{1, 3, 0, 0, 0, 0, 1, 2};
        tbl[23] = '{1, 3, 0, 0, 0, 0, 2, 3};
        tbl[24] = '{1, 3, 0, 0, 1, 0, 2, 3};
        tbl[25] = '{1, 3, 1, 0, 0, 0, 2, 3};

        reset      = 1'b0;
        play       = 1'b0;
        song       = 2'd0;
        reset_play = 1'b0;
        note_done  = 1'b0;
        step();
        step();
        chk("reset/note", note, 0);
        chk("reset/dur", duration, 0);
        chk("reset/new_note", new_note, 0);
        chk("reset/song_done", song_done, 0);
        reset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            play       = tbl[i].play;
            song       = tbl[i].song;
            reset_play = tbl[i].rp;
            note_done  = tbl[i].nd;
            step();
            chk($sformatf("vec%0d/new_note", i), new_note, tbl[i].nn);
            chk($sformatf("vec%0d/song_done", i), song_done, tbl[i].sd);
            chk($sformatf("vec%0d/note", i), note, tbl[i].note);
            chk($sformatf("vec%0d/dur", i), duration, tbl[i].dur);
        end
        reset_play = 1'b0;
        note_done  = 1'b0;

        // Song 0 with song input switched to 3 after the first note; song 3 only after DONE.
        play_song(0, 3);
        step();
        chk("s0_done_width/song_done", song_done, 0);
        chk("s0_done_width/new_note", new_note, 0);
        expect_note("s3_first", 4, 32, 48);
        reset_play = 1'b1;
        play       = 1'b0;
        step();
        reset_play = 1'b0;
        chk("rp_after_s3/new_note", new_note, 0);

        play_song(2, 2);
        play = 1'b0;
        step();
        chk("s2_done_width/song_done", song_done, 0);

        song = 2'd1;
        play = 1'b1;
        expect_note("s1_a", 4, 10, 12);
        note_done = 1'b1;
        expect_note("s1_b", 4, 20, 6);
        note_done = 1'b1;
`ifdef SONG_READER_ENDMARK_EN
        expect_done("s1_end", 4);
        play = 1'b0;
        step();
        chk("s1_end_after/new_note", new_note, 0);
        chk("s1_end_after/song_done", song_done, 0);
`else
        expect_note("s1_zero_word", 4, 0, 0);
        play = 1'b0;
`endif
        reset_play = 1'b1;
        step();
        reset_play = 1'b0;

        // Asynchronous reset in WAIT_NOTE, checked between clock edges.
        song = 2'd0;
        play = 1'b1;
        expect_note("pre_reset", 4, 1, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset/new_note", new_note, 0);
        chk("async_reset/song_done", song_done, 0);
        chk("async_reset/note", note, 0);
        chk("async_reset/dur", duration, 0);
        play = 1'b0;
        step();
        step();
        reset     = 1'b1;
        note_done = 1'b1;
        step();
        note_done = 1'b0;
        chk("idle_nd/new_note", new_note, 0);
        chk("idle_nd/song_done", song_done, 0);
        step();
        chk("idle_nd2/new_note", new_note, 0);
        play = 1'b1;
        expect_note("post_reset", 4, 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
